vending_customer: RTL
=====================

# vending_customer

Transaction-level initiator that drives the coin/select/return inputs of the vending machine and consumes its availability, item and coin-return outputs. Each accepted command buys one item. It inserts coins of one denomination until the machine reports the item available or the coin budget runs out. It then selects the item, waits for dispense, triggers change return, and totals the returned coins. It sits in the bench/system layer between a command source (testbench or host FSM) and the vending machine top.

## Interface

Parameters:
- NUM_COINS, 3, number of coin denominations
- NUM_ITEMS, 4, number of items
- COIN_VALUES, {16'd1000,16'd500,16'd100}, packed 16-bit value per coin index (index 0 in LSBs)
- TIMEOUT, 16, max cycles waited for item dispense

Ports:
- clk  in  1  clock; one clock; reset is asynchronous and active-high
- reset  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_item  in  2  item index to buy
- i_cmd_coin  in  2  coin index to insert
- i_cmd_max_coins  in  8  coin budget, 0 = no coins allowed
- o_input_coin  out  NUM_COINS  one-hot coin pulse to machine
- o_select_item  out  NUM_ITEMS  one-hot select pulse to machine
- o_trigger_return  out  1  change-return pulse to machine
- i_available_item  in  NUM_ITEMS  machine availability
- i_output_item  in  NUM_ITEMS  machine dispense sign
- i_return_coin  in  NUM_COINS  machine coin-return sign (multiple bits may be set)
- o_done  out  1  one-cycle completion pulse
- o_status  out  2  00 OK, 01 budget exhausted, 10 dispense timeout
- o_coins_spent  out  8  coins inserted this transaction
- o_change_total  out  16  summed value of returned coins

## Operation

States: IDLE, CHECK, INSERT, GAP, SELECT, WAIT_ITEM, RETURN, COLLECT, DONE.
- IDLE: o_cmd_ready=1. On i_cmd_valid, latch item, coin and budget. Clear counters. Go to CHECK.
- CHECK: if i_available_item[item] → SELECT. Else if coins_spent == budget → status 01, go to RETURN. Else → INSERT.
- INSERT: o_input_coin = one-hot(coin) for exactly one cycle. coins_spent++. → GAP.
- GAP: one idle cycle so the machine balance settles. → CHECK.
- SELECT: o_select_item = one-hot(item) for one cycle. Clear the wait counter. → WAIT_ITEM.
- WAIT_ITEM: if i_output_item[item] → RETURN with status 00. Else increment the wait counter. At TIMEOUT cycles → RETURN with status 10.
- RETURN: o_trigger_return=1 for one cycle. → COLLECT.
- COLLECT: each cycle, add the COIN_VALUES of every set i_return_coin bit to change_total. Leave when i_return_coin==0 for 2 consecutive cycles. → DONE.
- DONE: o_done=1 for one cycle. Results stay stable until the next command is accepted. → IDLE.

Arithmetic:
- change_total is 16-bit and wraps modulo 2^16; no saturation.
- coins_spent is 8-bit and never exceeds the budget.

Boundary conditions:
- Budget 0 with the item already available: select with no insert.
- Budget 0 with the item unavailable: status 01, no coin pulse.
- i_cmd_valid outside IDLE is ignored; no queueing.
- Out-of-range i_cmd_item or i_cmd_coin (≥ NUM_*): drive no pulse for that field; the transaction ends with status 01 or 10.
- i_output_item bits for other items are ignored.

## Timing

- Reset (asynchronous, takes effect immediately): state IDLE; all pulse outputs 0; o_done=0; o_status=00; o_coins_spent=0; o_change_total=0; o_cmd_ready=1 after reset releases.
- Reset mid-transaction aborts with no o_done. Pulse outputs drop in the same cycle reset asserts.
- All outputs are registered.
- Command accept → first coin pulse: 2 cycles (IDLE→CHECK→INSERT).
- Each coin costs 3 cycles (INSERT, GAP, CHECK).
- i_output_item is sampled from the cycle after the select pulse.
- Return pulse → DONE is at least 3 cycles.

## Test plan

- Item 0 (400), coin 0 (100), budget 10 → four 100 pulses, select item 0, dispense, no return coins; status 00, spent 4, change 0.
- Item 0, coin 1 (500), budget 3 → one 500 pulse, select, return 100; status 00, spent 1, change 100.
- Item 3 (2000), coin 0, budget 5 → five 100 pulses, no select, trigger return, collect 500; status 01, spent 5, change 500.
- Machine model never dispenses, item 1, coin 1, budget 2 → one pulse, select, 16 wait cycles, return pulse; status 10, change 0.
- Assert reset during the GAP after the 2nd coin → all outputs 0 immediately, ready=1 after release. A fresh command then runs to status 00.
- i_cmd_valid held high during WAIT_ITEM with a different item → ignored. Exactly one o_done for the first command; the next command is accepted only in IDLE.

Source files
------------

// File: rtl/vending_customer_if.sv
// Command, machine-drive and machine-sense signals of the vending customer,
// bundled so the customer and its environment connect through one port.
interface vending_customer_if #(
    parameter int NUM_COINS = 3,
    parameter int NUM_ITEMS = 4
);
    logic                 i_cmd_valid;
    logic                 o_cmd_ready;
    logic [1:0]           i_cmd_item;
    logic [1:0]           i_cmd_coin;
    logic [7:0]           i_cmd_max_coins;
    logic [NUM_COINS-1:0] o_input_coin;
    logic [NUM_ITEMS-1:0] o_select_item;
    logic                 o_trigger_return;
    logic [NUM_ITEMS-1:0] i_available_item;
    logic [NUM_ITEMS-1:0] i_output_item;
    logic [NUM_COINS-1:0] i_return_coin;
    logic                 o_done;
    logic [1:0]           o_status;
    logic [7:0]           o_coins_spent;
    logic [15:0]          o_change_total;

    modport master (
        input  i_cmd_valid, i_cmd_item, i_cmd_coin, i_cmd_max_coins,
               i_available_item, i_output_item, i_return_coin,
        output o_cmd_ready, o_input_coin, o_select_item, o_trigger_return,
               o_done, o_status, o_coins_spent, o_change_total
    );

    modport slave (
        output i_cmd_valid, i_cmd_item, i_cmd_coin, i_cmd_max_coins,
               i_available_item, i_output_item, i_return_coin,
        input  o_cmd_ready, o_input_coin, o_select_item, o_trigger_return,
               o_done, o_status, o_coins_spent, o_change_total
    );
endinterface

// File: rtl/vending_customer.sv
// Buys one item per command: feeds coins until the item is available or the
// budget is spent, selects, waits for dispense, then collects the change.
module vending_customer #(
    parameter int NUM_COINS = 3,
    parameter int NUM_ITEMS = 4,
    parameter logic [16*NUM_COINS-1:0] COIN_VALUES = {16'd1000, 16'd500, 16'd100},
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    vending_customer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHECK     = 4'd1,
        S_INSERT    = 4'd2,
        S_GAP       = 4'd3,
        S_SELECT    = 4'd4,
        S_WAIT_ITEM = 4'd5,
        S_RETURN    = 4'd6,
        S_COLLECT   = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    localparam logic [1:0]  ST_OK      = 2'b00;
    localparam logic [1:0]  ST_BUDGET  = 2'b01;
    localparam logic [1:0]  ST_TIMEOUT = 2'b10;
    localparam logic [15:0] TIMEOUT_L  = 16'(TIMEOUT);

    state_t               state_q, state_d;
    logic [1:0]           item_q, item_d, coin_q, coin_d;
    logic [7:0]           budget_q, budget_d, spent_q, spent_d;
    logic [15:0]          wait_q, wait_d, change_q, change_d;
    logic                 zero_q, zero_d;
    logic [1:0]           status_q, status_d;
    logic                 ready_q, ready_d, trig_q, trig_d, done_q, done_d;
    logic [NUM_COINS-1:0] coin_pulse_q, coin_pulse_d;
    logic [NUM_ITEMS-1:0] sel_pulse_q, sel_pulse_d;
    logic                 item_avail_s, item_out_s;

    // Out-of-range indices map to an all-zero vector, so no pulse is driven.
    function automatic logic [NUM_COINS-1:0] coin_onehot(input logic [1:0] idx);
        logic [NUM_COINS-1:0] v;
        for (int i = 0; i < NUM_COINS; i++) v[i] = (int'(idx) == i);
        return v;
    endfunction

    function automatic logic [NUM_ITEMS-1:0] item_onehot(input logic [1:0] idx);
        logic [NUM_ITEMS-1:0] v;
        for (int i = 0; i < NUM_ITEMS; i++) v[i] = (int'(idx) == i);
        return v;
    endfunction

    function automatic logic item_bit(input logic [NUM_ITEMS-1:0] vec, input logic [1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) hit = hit | (vec[i] & (int'(idx) == i));
        return hit;
    endfunction

    function automatic logic [15:0] coin_sum(input logic [NUM_COINS-1:0] bits);
        logic [15:0] s;
        s = 16'd0;
        for (int i = 0; i < NUM_COINS; i++) s = s + (bits[i] ? COIN_VALUES[16*i +: 16] : 16'd0);
        return s;
    endfunction

    assign item_avail_s = item_bit(bus.i_available_item, item_q);
    assign item_out_s   = item_bit(bus.i_output_item, item_q);

    // Next-state, counters, and output lookahead so every output comes from a flop.
    always_comb begin
        state_d  = state_q;
        item_d   = item_q;
        coin_d   = coin_q;
        budget_d = budget_q;
        spent_d  = spent_q;
        wait_d   = wait_q;
        change_d = change_q;
        zero_d   = zero_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_cmd_valid) begin
                    item_d   = bus.i_cmd_item;
                    coin_d   = bus.i_cmd_coin;
                    budget_d = bus.i_cmd_max_coins;
                    spent_d  = 8'd0;
                    wait_d   = 16'd0;
                    change_d = 16'd0;
                    zero_d   = 1'b0;
                    status_d = ST_OK;
                    state_d  = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (item_avail_s) begin
                    state_d = S_SELECT;
                end else if (spent_q == budget_q) begin
                    status_d = ST_BUDGET;
                    state_d  = S_RETURN;
                end else begin
                    state_d = S_INSERT;
                end
            end
            S_INSERT: begin
                spent_d = spent_q + 8'd1;
                state_d = S_GAP;
            end
            S_GAP:    state_d = S_CHECK;
            S_SELECT: begin
                wait_d  = 16'd0;
                state_d = S_WAIT_ITEM;
            end
            S_WAIT_ITEM: begin
                if (item_out_s) begin
                    status_d = ST_OK;
                    state_d  = S_RETURN;
                end else begin
                    wait_d = wait_q + 16'd1;
                    if (wait_d == TIMEOUT_L) begin
                        status_d = ST_TIMEOUT;
                        state_d  = S_RETURN;
                    end else begin
                        state_d = S_WAIT_ITEM;
                    end
                end
            end
            S_RETURN: begin
                zero_d  = 1'b0;
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                change_d = change_q + coin_sum(bus.i_return_coin);
                if (bus.i_return_coin == '0) begin
                    if (zero_q) begin
                        state_d = S_DONE;
                    end else begin
                        zero_d = 1'b1;
                    end
                end else begin
                    zero_d = 1'b0;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        ready_d      = (state_d == S_IDLE);
        coin_pulse_d = (state_d == S_INSERT) ? coin_onehot(coin_d) : '0;
        sel_pulse_d  = (state_d == S_SELECT) ? item_onehot(item_d) : '0;
        trig_d       = (state_d == S_RETURN);
        done_d       = (state_d == S_DONE);
    end

    // State, transaction context and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            item_q       <= 2'd0;
            coin_q       <= 2'd0;
            budget_q     <= 8'd0;
            spent_q      <= 8'd0;
            wait_q       <= 16'd0;
            change_q     <= 16'd0;
            zero_q       <= 1'b0;
            status_q     <= ST_OK;
            ready_q      <= 1'b1;
            coin_pulse_q <= '0;
            sel_pulse_q  <= '0;
            trig_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            item_q       <= item_d;
            coin_q       <= coin_d;
            budget_q     <= budget_d;
            spent_q      <= spent_d;
            wait_q       <= wait_d;
            change_q     <= change_d;
            zero_q       <= zero_d;
            status_q     <= status_d;
            ready_q      <= ready_d;
            coin_pulse_q <= coin_pulse_d;
            sel_pulse_q  <= sel_pulse_d;
            trig_q       <= trig_d;
            done_q       <= done_d;
        end
    end

    assign bus.o_cmd_ready      = ready_q;
    assign bus.o_input_coin     = coin_pulse_q;
    assign bus.o_select_item    = sel_pulse_q;
    assign bus.o_trigger_return = trig_q;
    assign bus.o_done           = done_q;
    assign bus.o_status         = status_q;
    assign bus.o_coins_spent    = spent_q;
    assign bus.o_change_total   = change_q;
endmodule
